ccff_bitstream_loader: RTL

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

---
 rtl/ccff_bitstream_loader_pkg.sv | 30 +++
 rtl/ccff_crc8_serial.sv | 45 ++++
 rtl/ccff_bitstream_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ccff_bitstream_loader_pkg.sv
// -----------------------------------------------------------------------------
// ccff_bitstream_loader_pkg
// Shared definitions for the configuration-chain bitstream loader:
//   - ccff_state_e      : loader FSM state encoding (also driven on dbg_state)
//   - CRC8_POLY         : CRC-8 polynomial for the optional tail read-back
//   - DEFAULT_CHAIN_LEN : default chain length (4 mux memories x 3 bits)
//   - DEFAULT_DATA_W    : default bitstream word width
//   - crc8_step()       : one MSB-first bitwise CRC-8 update
// -----------------------------------------------------------------------------
package ccff_bitstream_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam int         DEFAULT_CHAIN_LEN = 12;
  localparam int         DEFAULT_DATA_W    = 8;

  // Feedback is the outgoing MSB XORed with the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// -----------------------------------------------------------------------------
// ccff_crc8_serial
// Serial CRC-8 (init 0x00, MSB-first) over one bit per enabled clock.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the CRC
//   en      : fold bit_in into the CRC on this edge
//   clr     : synchronous clear to 0x00 (takes priority over en)
//   bit_in  : serial data bit
//   crc     : current CRC value
// -----------------------------------------------------------------------------
module ccff_crc8_serial
  import ccff_bitstream_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_d;
  logic [7:0] crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// -----------------------------------------------------------------------------
// ccff_bitstream_loader
// Streams bitstream words MSB-first into a serial configuration chain.
// Optional feature macro: CCFF_LOADER_READBACK_CRC_EN adds a CRC-8 over the
// bits returned on ccff_tail (output rb_crc).
// Ports:
//   prog_clk   : clock, rising edge
//   prog_reset : asynchronous active-high reset
//   start      : begins a load (only honoured in IDLE or DONE)
//   s_data     : bitstream word, MSB shifted first
//   s_valid    : word offered
//   s_ready    : word accepted on an edge with s_valid (high only in LOAD)
//   ccff_head  : serial bit to the chain head (0 outside SHIFT)
//   shift_en   : chain capture enable (high only in SHIFT)
//   ccff_tail  : serial bit from the chain tail (used only for read-back CRC)
//   busy       : high in LOAD or SHIFT
//   done       : high in DONE
//   dbg_state  : current FSM state
//   rb_crc     : read-back CRC-8 (only with CCFF_LOADER_READBACK_CRC_EN)
// Handshake: a word transfers on a rising edge where s_valid and s_ready are
// both high; s_valid is never consumed while s_ready is low, and s_data only
// has to be stable on the transfer edge.
// -----------------------------------------------------------------------------
module ccff_bitstream_loader
  import ccff_bitstream_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int DATA_W    = DEFAULT_DATA_W
)
(
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output ccff_state_e       dbg_state
`ifdef CCFF_LOADER_READBACK_CRC_EN
  ,
  output logic [7:0]        rb_crc
`endif
);

  // Bit counter holds values 0..CHAIN_LEN; word counter holds 0..DATA_W-1.
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WORD_BIT = WB_W'(DATA_W - 1);

  ccff_state_e       state_d,     state_q;
  logic [DATA_W-1:0] sreg_d,      sreg_q;
  logic [CNT_W-1:0]  bit_cnt_d,   bit_cnt_q;
  logic [WB_W-1:0]   word_bit_d,  word_bit_q;
  logic              s_ready_d,   s_ready_q;
  logic              shift_en_d,  shift_en_q;
  logic              ccff_head_d, ccff_head_q;
  logic              busy_d,      busy_q;
  logic              done_d,      done_q;
  logic              load_start;

  assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_bit_d = word_bit_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          bit_cnt_d  = '0;
          word_bit_d = '0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          sreg_d     = s_data;
          word_bit_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d     = sreg_q << 1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        word_bit_d = word_bit_q + 1'b1;
        // Chain end wins over word end: leftover low bits are dropped.
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end else if (word_bit_q == LAST_WORD_BIT) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    s_ready_d   = (state_d == ST_LOAD);
    shift_en_d  = (state_d == ST_SHIFT);
    ccff_head_d = shift_en_d ? sreg_d[DATA_W-1] : 1'b0;
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      word_bit_q  <= '0;
      s_ready_q   <= 1'b0;
      shift_en_q  <= 1'b0;
      ccff_head_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_bit_q  <= word_bit_d;
      s_ready_q   <= s_ready_d;
      shift_en_q  <= shift_en_d;
      ccff_head_q <= ccff_head_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign shift_en  = shift_en_q;
  assign ccff_head = ccff_head_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef CCFF_LOADER_READBACK_CRC_EN
  // The tail bit is sampled on the same edge the chain captures ccff_head.
  ccff_crc8_serial u_crc (
    .clk    (prog_clk),
    .rst    (prog_reset),
    .en     (shift_en_q),
    .clr    (load_start),
    .bit_in (ccff_tail),
    .crc    (rb_crc)
  );
`else
  logic unused_readback;
  assign unused_readback = ccff_tail ^ load_start;
`endif

endmodule
